sprite_pixel_reader: RTL and testbench
======================================

# sprite_pixel_reader

Raster-side reader for the 256x256 2-bit sprite framebuffer. It fetches packed 32-bit words from framebuffer memory over a request/valid handshake and unpacks them MSB-first into one 2-bit pixel per clock. The output is aligned to the row/column counters from the VGA sync generator and feeds the palette/colour stage ahead of the VGA pins. It is the read-side counterpart of the pixel packer: 16 pixels per word, first pixel in bits [31:30].

## Interface
Parameters:
- WIN_X, 16, first window column; must be >= 16 so the row prefetch completes before the first pixel.
- WIN_Y, 0, first window row.

Ports (one clock; reset is synchronous and active-high):
- i_Clk  input  1  system clock, pixel rate.
- i_Reset  input  1  synchronous active-high reset.
- i_Row  input  10  current raster row.
- i_Column  input  10  current raster column; advances by 1 per clock within a row.
- o_Rd_Req  output  1  single-cycle read request pulse.
- o_Rd_Addr  output  12  word address {row-WIN_Y [7:0], word index [3:0]}; valid while o_Rd_Req is high.
- i_Rd_Valid  input  1  one-cycle response strobe.
- i_Rd_Data  input  32  response word; valid while i_Rd_Valid is high.
- o_Pixel  output  2  pixel for the column presented on the previous clock.
- o_Pixel_Valid  output  1  high when o_Pixel belongs to the window.
- o_Underrun  output  1  sticky flag: a word was needed and not yet returned.

## Operation
- Window: rows WIN_Y..WIN_Y+255, columns WIN_X..WIN_X+255. 16 words per row, 4096 words per frame.
- In window, k = column-WIN_X, word w = k>>4, slot s = k&15.
- State:
  - 32-bit shift register SR.
  - 32-bit holding register HOLD with a HOLD_FULL flag.
  - OUTSTANDING flag.
  - FSM: IDLE, FETCH, READY, ACTIVE.
- IDLE:
  - When column==0 and the row is in the window: pulse o_Rd_Req with addr {row-WIN_Y, 0}, set OUTSTANDING, go to FETCH.
  - Otherwise no requests.
- FETCH: on i_Rd_Valid, HOLD<=i_Rd_Data, HOLD_FULL<=1, OUTSTANDING<=0, go to READY.
- READY: at column==WIN_X, go to ACTIVE and apply the slot-0 action below in the same cycle.
- ACTIVE, slot 0:
  - If HOLD_FULL: o_Pixel<=HOLD[31:30], SR<=HOLD<<2, HOLD_FULL<=0. If w<15, pulse a request for word w+1 and set OUTSTANDING.
  - If not HOLD_FULL: o_Pixel<=0, SR<=0, o_Underrun<=1. If w<15 and no request is outstanding, request word w+1 anyway.
- ACTIVE, slots 1..15: o_Pixel<=SR[31:30], SR<=SR<<2.
- A response arriving in ACTIVE loads HOLD and clears OUTSTANDING.
- After column WIN_X+255, return to IDLE.
- The FSM also returns to IDLE whenever the row is outside the window.
- i_Rd_Valid while OUTSTANDING==0 is ignored.
- At most one request is in flight at any time.
- Outside the window: o_Pixel=0, o_Pixel_Valid=0.
- Address arithmetic is 8-bit row offset by 4-bit word index. No wrap: the row check excludes rows >= WIN_Y+256.

## Timing
- Reset values: o_Pixel=0, o_Pixel_Valid=0, o_Rd_Req=0, o_Rd_Addr=0, o_Underrun=0. SR, HOLD, HOLD_FULL, OUTSTANDING and FSM are cleared; FSM=IDLE.
- Reset mid-operation:
  - Any in-flight response is discarded because OUTSTANDING is cleared.
  - No request is issued until the next column==0 of a window row.
- Latency: o_Pixel/o_Pixel_Valid are registered, one clock after the matching i_Row/i_Column.
- Memory latency (request to i_Rd_Valid) must be 1..15 clocks for underrun-free operation:
  - The first word has WIN_X clocks of slack.
  - Each later word has 16 clocks of slack.
- Request cadence per row:
  - Word 0 at column 0.
  - Words 1..15 at columns WIN_X+16·w-16, for w=1..15 (i.e., at each slot-0 column).
- Simultaneous i_Rd_Valid and slot 0 with HOLD empty: treated as underrun. The arriving word loads HOLD for use at the next slot 0.

## Test plan
- Reset held for 3 clocks, then row 300: every output is 0 and no o_Rd_Req is issued.
- Row 0, all words 0x1B1B1B1B, memory latency 1:
  - o_Pixel sequence is 0,1,2,3 repeating.
  - o_Pixel_Valid is high for exactly 256 clocks, for column inputs 16..271.
- Row 5:
  - o_Rd_Addr sequence is 0x050..0x05F.
  - Requests occur at columns 0, 16, 32, …, 240.
- Memory latency 15 with distinct per-word patterns: all pixels correct, o_Underrun stays 0.
- Memory latency 20: o_Underrun rises at column 32 and the 16 pixels of that word read 0.
- Reset asserted at column 100 of row 3:
  - Outputs are 0 on the next clock.
  - A late i_Rd_Valid is ignored.
  - Row 4 is output correctly starting with its column-0 request.

Source files
------------

// File: rtl/sprite_pixel_reader_if.sv
// Read-side bus between the sprite pixel reader and framebuffer memory.
// The reader issues single-cycle requests; memory answers with a one-cycle strobe.
interface sprite_pixel_reader_if;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/sprite_pixel_reader.sv
// Raster-side reader for the 256x256 2-bit sprite framebuffer.
// Fetches one 32-bit word per 16 pixels and unpacks it MSB-first, one pixel per clock,
// one clock behind the row/column counters.
module sprite_pixel_reader #(
  parameter int unsigned WIN_X = 16,
  parameter int unsigned WIN_Y = 0
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic [9:0]                  i_Row,
  input  logic [9:0]                  i_Column,
  sprite_pixel_reader_if.master       rd_bus,
  output logic [1:0]                  o_Pixel,
  output logic                        o_Pixel_Valid,
  output logic                        o_Underrun
);

  localparam logic [10:0] XLo = 11'(WIN_X);
  localparam logic [10:0] XHi = 11'(WIN_X + 256);
  localparam logic [10:0] YLo = 11'(WIN_Y);
  localparam logic [10:0] YHi = 11'(WIN_Y + 256);

  typedef enum logic [1:0] {StIdle, StFetch, StReady, StActive} state_e;

  state_e      state_q;
  logic [31:0] sr_q;
  logic [31:0] hold_q;
  logic        hold_full_q;
  logic        outstanding_q;

  logic        in_row;
  logic        in_win;
  logic [7:0]  row_k;
  logic [7:0]  col_k;
  logic        rsp_take;
  logic        slot0;
  logic        shift_slot;
  logic        req;
  logic [11:0] addr;

  assign in_row = ({1'b0, i_Row} >= YLo) && ({1'b0, i_Row} < YHi);
  assign in_win = in_row && ({1'b0, i_Column} >= XLo) && ({1'b0, i_Column} < XHi);
  assign row_k  = 8'(i_Row - 10'(WIN_Y));
  assign col_k  = 8'(i_Column - 10'(WIN_X));

  // Responses with nothing in flight (e.g. after reset) are dropped here.
  assign rsp_take = rd_bus.rd_valid && outstanding_q;

  // A late first word (still in FETCH at the window start) is handled as an underrun
  // rather than leaving the row stuck.
  assign slot0 = in_win && (col_k[3:0] == 4'd0) &&
                 ((state_q == StActive) ||
                  (((state_q == StFetch) || (state_q == StReady)) && (col_k == 8'd0)));
  assign shift_slot = (state_q == StActive) && in_win && (col_k[3:0] != 4'd0);

  // Requests are decoded from the current counters so memory sees them in the slot-0 cycle.
  always_comb begin
    req  = 1'b0;
    addr = 12'd0;
    if (!i_Reset) begin
      if (state_q == StIdle) begin
        if ((i_Column == 10'd0) && in_row) begin
          req  = 1'b1;
          addr = {row_k, 4'd0};
        end
      end else if (slot0 && (col_k[7:4] != 4'hF) && (hold_full_q || !outstanding_q)) begin
        req  = 1'b1;
        addr = {row_k, 4'(col_k[7:4] + 4'd1)};
      end
    end
  end

  assign rd_bus.rd_req  = req;
  assign rd_bus.rd_addr = addr;

  // Datapath, handshake bookkeeping and FSM.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= StIdle;
      sr_q          <= 32'd0;
      hold_q        <= 32'd0;
      hold_full_q   <= 1'b0;
      outstanding_q <= 1'b0;
      o_Pixel       <= 2'b00;
      o_Pixel_Valid <= 1'b0;
      o_Underrun    <= 1'b0;
    end else begin
      o_Pixel       <= 2'b00;
      o_Pixel_Valid <= 1'b0;

      if (rsp_take) begin
        hold_q        <= rd_bus.rd_data;
        hold_full_q   <= 1'b1;
        outstanding_q <= 1'b0;
      end
      if (req) begin
        outstanding_q <= 1'b1;
      end

      if (slot0) begin
        o_Pixel_Valid <= 1'b1;
        if (hold_full_q) begin
          o_Pixel     <= hold_q[31:30];
          sr_q        <= {hold_q[29:0], 2'b00};
          hold_full_q <= 1'b0;
        end else begin
          // A word arriving in this same cycle stays in HOLD for the next slot 0.
          sr_q       <= 32'd0;
          o_Underrun <= 1'b1;
        end
      end
      if (shift_slot) begin
        o_Pixel_Valid <= 1'b1;
        o_Pixel       <= sr_q[31:30];
        sr_q          <= {sr_q[29:0], 2'b00};
      end

      unique case (state_q)
        StIdle: begin
          if ((i_Column == 10'd0) && in_row) state_q <= StFetch;
        end
        StFetch, StReady: begin
          if (!in_row || ({1'b0, i_Column} >= XHi)) state_q <= StIdle;
          else if (slot0)                           state_q <= StActive;
          else if (rsp_take)                        state_q <= StReady;
        end
        StActive: begin
          if (!in_win || (col_k == 8'd255)) state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Randomized self-checking bench for sprite_pixel_reader with a queue-based memory model.
module tb_sprite_pixel_reader;
  localparam int WX      = 16;
  localparam int WY      = 0;
  localparam int ROW_LEN = 290;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] row;
  logic [9:0] col;
  logic [1:0] pix;
  logic       pv;
  logic       ur;

  always #5 clk = ~clk;

  sprite_pixel_reader_if bus ();

  sprite_pixel_reader #(.WIN_X(WX), .WIN_Y(WY)) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .i_Row         (row),
    .i_Column      (col),
    .rd_bus        (bus),
    .o_Pixel       (pix),
    .o_Pixel_Valid (pv),
    .o_Underrun    (ur)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] mem [4096];
  rsp_t        pend [$];
  int          cyc;
  int          n_vec;
  int          n_err;
  int          lat_first;
  int          lat_rest;
  bit          lat_rand;
  bit          chk_pix;
  bit          chk_req;
  bit          exp_ur;
  int          valid_cnt;
  int          req_cnt;
  int          prev_row;
  int          prev_col;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (prev row %0d col %0d)",
               tag, got, exp, prev_row, prev_col);
    end
  endtask

  function automatic bit row_in(int r);
    return (r >= WY) && (r < WY + 256);
  endfunction

  function automatic bit win_in(int r, int c);
    return row_in(r) && (c >= WX) && (c < WX + 256);
  endfunction

  function automatic logic [1:0] ref_pix(int r, int c);
    int k;
    logic [31:0] w;
    k = c - WX;
    w = mem[(r - WY) * 16 + k / 16];
    return 2'((w >> (30 - 2 * (k % 16))) & 32'd3);
  endfunction

  function automatic bit ref_req(int r, int c);
    return row_in(r) && ((c == 0) || ((c >= WX) && (c < WX + 240) && ((c - WX) % 16 == 0)));
  endfunction

  function automatic int ref_addr(int r, int c);
    return (c == 0) ? (r - WY) * 16 : (r - WY) * 16 + (c - WX) / 16 + 1;
  endfunction

  // One clock: drive inputs, serve memory, check outputs of the previous clock.
  task automatic step(int r, int c, bit rs);
    int lat;
    @(posedge clk);
    #1;
    row = 10'(r);
    col = 10'(c);
    rst = rs;
    cyc++;
    bus.rd_valid = 1'b0;
    bus.rd_data  = 32'd0;
    if ((pend.size() > 0) && (pend[0].due == cyc)) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = pend[0].data;
      void'(pend.pop_front());
    end
    @(negedge clk);
    if (bus.rd_req) begin
      req_cnt++;
      if (lat_rand) lat = int'($urandom_range(1, 15));
      else          lat = (bus.rd_addr[3:0] == 4'd0) ? lat_first : lat_rest;
      pend.push_back('{due: cyc + lat, data: mem[bus.rd_addr]});
    end
    if (chk_req) begin
      check("rd_req", 32'(bus.rd_req), 32'(ref_req(r, c)));
      if (ref_req(r, c) && bus.rd_req) check("rd_addr", 32'(bus.rd_addr), 32'(ref_addr(r, c)));
    end
    if (chk_pix) begin
      check("pixel_valid", 32'(pv), 32'(win_in(prev_row, prev_col)));
      check("pixel", 32'(pix),
            win_in(prev_row, prev_col) ? 32'(ref_pix(prev_row, prev_col)) : 32'd0);
      check("underrun", 32'(ur), 32'(exp_ur));
    end
    if (pv) valid_cnt++;
    prev_row = r;
    prev_col = c;
  endtask

  task automatic fill_row(int r);
    for (int w = 0; w < 16; w++) mem[(r - WY) * 16 + w] = $urandom;
  endtask

  task automatic run_row(int r);
    for (int c = 0; c < ROW_LEN; c++) step(r, c, 1'b0);
  endtask

  initial begin
    int rr;
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; row = 10'd300; col = 10'd0;
    bus.rd_valid = 1'b0; bus.rd_data = 32'd0;
    lat_first = 1; lat_rest = 1; lat_rand = 1'b0;
    chk_pix = 1'b0; chk_req = 1'b0; exp_ur = 1'b0;
    prev_row = 300; prev_col = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

    // Reset for 3 clocks, then an out-of-window row stays silent.
    for (int c = 0; c < 3; c++) step(300, c, 1'b1);
    chk_pix = 1'b1; chk_req = 1'b1;
    run_row(300);

    // Row 0, constant 0x1B pattern, latency 1.
    for (int w = 0; w < 16; w++) mem[w] = 32'h1B1B_1B1B;
    valid_cnt = 0;
    run_row(0);
    check("valid_count", 32'(valid_cnt), 32'd256);

    // Row 5: address sequence and request cadence.
    fill_row(5);
    req_cnt = 0;
    run_row(5);
    check("req_count", 32'(req_cnt), 32'd16);

    // First row past the window bottom.
    run_row(256);

    // Random rows with random latency 1..15.
    lat_rand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rr = int'($urandom_range(6, 255));
      fill_row(rr);
      run_row(rr);
    end
    lat_rand = 1'b0;

    // Worst-case latency 15 for every word.
    lat_first = 15; lat_rest = 15;
    fill_row(9);
    run_row(9);

    // Latency 20 after the first word: word 1 misses its slot at column 32.
    lat_first = 1; lat_rest = 20;
    fill_row(10);
    chk_req = 1'b0;
    for (int c = 0; c < ROW_LEN; c++) begin
      chk_pix = (c <= 32);
      step(10, c, 1'b0);
      if ((c >= 33) && (c <= 48)) begin
        check("underrun_pixel", 32'(pix), 32'd0);
        check("underrun_valid", 32'(pv), 32'd1);
      end
      if (c >= 33) check("underrun_sticky", 32'(ur), 32'd1);
    end

    // Reset at column 100 of row 3 with a request in flight.
    lat_first = 10; lat_rest = 10;
    fill_row(3);
    fill_row(4);
    chk_pix = 1'b1; chk_req = 1'b1; exp_ur = 1'b1;
    for (int c = 0; c < 100; c++) step(3, c, 1'b0);
    step(3, 100, 1'b1);
    chk_pix = 1'b0; chk_req = 1'b0;
    for (int c = 101; c < ROW_LEN; c++) begin
      step(3, c, 1'b0);
      check("rst_pixel", 32'(pix), 32'd0);
      check("rst_valid", 32'(pv), 32'd0);
      check("rst_underrun", 32'(ur), 32'd0);
      check("rst_req", 32'(bus.rd_req), 32'd0);
    end
    exp_ur = 1'b0; chk_pix = 1'b1; chk_req = 1'b1;
    run_row(4);
    step(300, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
